switch_io_ctrl: RTL and testbench



---
 rtl/switch_io_ctrl.sv | 113 +++++++++++
 tb/tb_switch_io_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_io_ctrl.sv
// rtl/switch_io_ctrl.sv - memory-mapped switch reader with sync, debounce, confirm snapshot and sticky status
module switch_io_ctrl #(
    parameter int          SW_WIDTH         = 16,
    parameter int          DEBOUNCE_CYCLES  = 20000,
    parameter logic [31:0] BASE_ADDR        = 32'hffff_fff0,
    parameter bit          LATCH_ON_CONFIRM = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SwitchCtrl,
    input  logic                io_write,
    input  logic [31:0]         address,
    input  logic [SW_WIDTH-1:0] switch_input,
    input  logic                confirmation,
    output logic [31:0]         data_IO_input,
    output logic                pending,
    output logic                overrun
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    // cnt counts matching comparisons; one more match makes DEBOUNCE_CYCLES equal samples
    localparam logic [CW-1:0] CNT_TH  = CW'(DEBOUNCE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, PRESSED} btn_state_t;

    logic [SW_WIDTH-1:0] sw_s1, sw_s2, sw_last, sw_db;
    logic [CW-1:0]       sw_cnt;
    logic                bt_s1, bt_s2, bt_last, bt_db;
    logic [CW-1:0]       bt_cnt;
    btn_state_t          btn_state;
    logic                confirm_pulse;
    logic [SW_WIDTH-1:0] snapshot, d_src;
    logic [7:0]          d_top;
    logic [31:0]         rd_value;
    logic                rd_hit, rd_data, wr_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            sw_last <= '0;
            sw_db   <= '0;
            sw_cnt  <= '0;
            bt_s1   <= 1'b0;
            bt_s2   <= 1'b0;
            bt_last <= 1'b0;
            bt_db   <= 1'b0;
            bt_cnt  <= '0;
        end else begin
            sw_s1   <= switch_input;
            sw_s2   <= sw_s1;
            sw_last <= sw_s2;
            if (sw_s2 != sw_last) begin
                sw_cnt <= '0;
            end else begin
                if (sw_cnt != CNT_MAX) sw_cnt <= sw_cnt + CW'(1);
                if (sw_cnt >= CNT_TH)  sw_db  <= sw_s2;
            end
            bt_s1   <= confirmation;
            bt_s2   <= bt_s1;
            bt_last <= bt_s2;
            if (bt_s2 != bt_last) begin
                bt_cnt <= '0;
            end else begin
                if (bt_cnt != CNT_MAX) bt_cnt <= bt_cnt + CW'(1);
                if (bt_cnt >= CNT_TH)  bt_db  <= bt_s2;
            end
        end
    end

    assign confirm_pulse = (btn_state == IDLE) && bt_db;
    assign d_src         = LATCH_ON_CONFIRM ? snapshot : sw_db;
    assign d_top         = d_src[SW_WIDTH-1 -: 8];

    always_comb begin
        rd_value = '0;
        rd_hit   = 1'b0;
        rd_data  = 1'b0;
        if (SwitchCtrl && !io_write) begin
            case (address)
                BASE_ADDR + 32'd1: begin rd_hit = 1'b1; rd_data = 1'b1; rd_value = 32'(d_src); end
                BASE_ADDR + 32'd3: begin rd_hit = 1'b1; rd_data = 1'b1; rd_value = {{24{d_top[7]}}, d_top}; end
                BASE_ADDR + 32'd5: begin rd_hit = 1'b1; rd_data = 1'b1; rd_value = {24'b0, d_top}; end
                BASE_ADDR + 32'd7: begin rd_hit = 1'b1; rd_data = 1'b1; rd_value = {24'b0, d_src[7:0]}; end
                BASE_ADDR + 32'd9: begin rd_hit = 1'b1; rd_value = {30'b0, overrun, pending}; end
                default: ;
            endcase
        end
    end

    assign wr_clr = SwitchCtrl && io_write && (address == BASE_ADDR + 32'd9);

    // A confirm press in the same cycle as a clear wins; overrun looks at pre-clear pending
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_state     <= IDLE;
            snapshot      <= '0;
            data_IO_input <= '0;
            pending       <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            case (btn_state)
                IDLE:    if (bt_db)  btn_state <= PRESSED;
                PRESSED: if (!bt_db) btn_state <= IDLE;
                default: btn_state <= IDLE;
            endcase
            if (confirm_pulse) snapshot <= sw_db;
            if (rd_hit) data_IO_input <= rd_value;
            pending <= confirm_pulse | (pending & ~(rd_data | wr_clr));
            overrun <= (confirm_pulse & pending) | (overrun & ~wr_clr);
        end
    end
endmodule

// File: tb/tb_switch_io_ctrl.sv
// tb/tb_switch_io_ctrl.sv - self-checking bench for switch_io_ctrl with a window-based reference model
module tb_switch_io_ctrl;
    localparam int          W    = 16;
    localparam int          DB   = 4;
    localparam logic [31:0] BASE = 32'hffff_fff0;

    logic          clk = 1'b0;
    logic          rst;
    logic          SwitchCtrl;
    logic          io_write;
    logic [31:0]   address;
    logic [W-1:0]  switch_input;
    logic          confirmation;
    logic [31:0]   data_IO_input;
    logic          pending;
    logic          overrun;

    int checks   = 0;
    int failures = 0;

    switch_io_ctrl #(
        .SW_WIDTH(W),
        .DEBOUNCE_CYCLES(DB),
        .BASE_ADDR(BASE),
        .LATCH_ON_CONFIRM(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .SwitchCtrl(SwitchCtrl),
        .io_write(io_write),
        .address(address),
        .switch_input(switch_input),
        .confirmation(confirmation),
        .data_IO_input(data_IO_input),
        .pending(pending),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: raw input windows; a value is debounced once DB equal samples sit behind the 2-flop sync
    logic [W-1:0]  sw_h [0:DB+1];
    logic          bt_h [0:DB+1];
    logic [W-1:0]  m_db, m_snap;
    logic          m_bdb, m_pulse_due, m_pend, m_ovr, m_live = 1'b0;
    logic [31:0]   m_data, m_off;
    logic          m_pulse, m_pend_old, m_clr_p, m_clr_o, m_eq, m_beq, m_bnew;
    logic [7:0]    m_top;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= DB + 1; k++) begin
                sw_h[k] = '0;
                bt_h[k] = 1'b0;
            end
            m_db = '0; m_snap = '0; m_bdb = 1'b0; m_pulse_due = 1'b0;
            m_pend = 1'b0; m_ovr = 1'b0; m_data = '0; m_live = 1'b1;
        end else begin
            m_pulse    = m_pulse_due;
            m_pend_old = m_pend;
            m_clr_p    = 1'b0;
            m_clr_o    = 1'b0;
            m_off      = address - BASE;
            m_top      = m_snap[W-1:W-8];
            if (SwitchCtrl && !io_write) begin
                case (m_off)
                    32'd1: begin m_data = {16'h0, m_snap};                     m_clr_p = 1'b1; end
                    32'd3: begin m_data = m_top[7] ? {24'hffffff, m_top} : {24'h0, m_top}; m_clr_p = 1'b1; end
                    32'd5: begin m_data = {24'h0, m_top};                      m_clr_p = 1'b1; end
                    32'd7: begin m_data = {24'h0, m_snap[7:0]};                m_clr_p = 1'b1; end
                    32'd9: m_data = {30'h0, m_ovr, m_pend};
                    default: ;
                endcase
            end
            if (SwitchCtrl && io_write && m_off == 32'd9) begin
                m_clr_p = 1'b1;
                m_clr_o = 1'b1;
            end
            if (m_clr_p) m_pend = 1'b0;
            if (m_clr_o) m_ovr  = 1'b0;
            if (m_pulse) begin
                if (m_pend_old) m_ovr = 1'b1;
                m_pend = 1'b1;
                m_snap = m_db;
            end
            for (int k = DB + 1; k > 0; k--) begin
                sw_h[k] = sw_h[k-1];
                bt_h[k] = bt_h[k-1];
            end
            sw_h[0] = switch_input;
            bt_h[0] = confirmation;
            m_eq  = 1'b1;
            m_beq = 1'b1;
            for (int k = 3; k <= DB + 1; k++) begin
                if (sw_h[k] != sw_h[2]) m_eq = 1'b0;
                if (bt_h[k] != bt_h[2]) m_beq = 1'b0;
            end
            if (m_eq) m_db = sw_h[2];
            m_bnew      = m_beq ? bt_h[2] : m_bdb;
            m_pulse_due = m_bnew && !m_bdb;
            m_bdb       = m_bnew;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_data", data_IO_input, m_data);
            chk("model_pending", {31'h0, pending}, {31'h0, m_pend});
            chk("model_overrun", {31'h0, overrun}, {31'h0, m_ovr});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] off);
        SwitchCtrl = 1'b1; io_write = 1'b0; address = BASE + off;
        step(1);
        SwitchCtrl = 1'b0; address = '0;
    endtask

    task automatic press();
        confirmation = 1'b1; step(6);
        confirmation = 1'b0; step(8);
    endtask

    initial begin
        rst = 1'b1; SwitchCtrl = 1'b0; io_write = 1'b0; address = '0;
        switch_input = 16'hA5C3; confirmation = 1'b0;
        step(3);
        rst = 1'b0;
        chk("reset_data", data_IO_input, 32'h0);
        chk("reset_pending", {31'h0, pending}, 32'h0);
        step(10);
        rd(1); chk("t1_rd1", data_IO_input, 32'h0);
        rd(9); chk("t1_rd9", data_IO_input, 32'h0);
        chk("t1_pending", {31'h0, pending}, 32'h0);

        switch_input = 16'h80F0; step(8);
        confirmation = 1'b1; step(10);
        confirmation = 1'b0; step(8);
        chk("t2_pending", {31'h0, pending}, 32'h1);
        chk("t2_single_pulse", {31'h0, overrun}, 32'h0);
        rd(1); chk("t2_rd1", data_IO_input, 32'h0000_80F0);
        chk("t2_clear_on_read", {31'h0, pending}, 32'h0);
        rd(3); chk("t2_rd3", data_IO_input, 32'hFFFF_FF80);
        rd(5); chk("t2_rd5", data_IO_input, 32'h0000_0080);
        rd(7); chk("t2_rd7", data_IO_input, 32'h0000_00F0);

        for (int i = 0; i < 4; i++) begin
            confirmation = ~i[0]; step(1);
        end
        confirmation = 1'b1; step(6);
        chk("t3_no_early_pulse", {31'h0, pending}, 32'h0);
        confirmation = 1'b0; step(1);
        chk("t3_pulse_at_6", {31'h0, pending}, 32'h1);
        step(8);
        chk("t3_single_pulse", {31'h0, overrun}, 32'h0);

        rd(1); chk("t4_rd1", data_IO_input, 32'h0000_80F0);
        press();
        press();
        rd(9); chk("t4_status", data_IO_input, 32'h3);
        SwitchCtrl = 1'b1; io_write = 1'b1; address = BASE + 32'd9;
        step(1);
        SwitchCtrl = 1'b0; io_write = 1'b0; address = '0;
        chk("t4_write_holds_data", data_IO_input, 32'h3);
        rd(9); chk("t4_status_cleared", data_IO_input, 32'h0);

        switch_input = 16'h1234; step(8);
        confirmation = 1'b1; step(6);
        rd(1);
        chk("t5_old_snapshot", data_IO_input, 32'h0000_80F0);
        chk("t5_set_wins", {31'h0, pending}, 32'h1);
        step(2);
        confirmation = 1'b0; step(8);
        rd(1); chk("t5_new_snapshot", data_IO_input, 32'h0000_1234);

        press();
        switch_input = 16'h5555; step(2);
        switch_input = 16'h0F0F; step(2);
        rst = 1'b1; step(1);
        chk("t6_rst_data", data_IO_input, 32'h0);
        chk("t6_rst_pending", {31'h0, pending}, 32'h0);
        chk("t6_rst_overrun", {31'h0, overrun}, 32'h0);
        rst = 1'b0; confirmation = 1'b1; step(1);
        switch_input = 16'h3C3C; step(8);
        confirmation = 1'b0; step(8);
        chk("t6_pending", {31'h0, pending}, 32'h1);
        rd(1); chk("t6_snap_not_ready", data_IO_input, 32'h0);
        press();
        rd(1); chk("t6_snap_ready", data_IO_input, 32'h0000_3C3C);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
